// File: rtl/t08_wb_multi_master.sv
// Round-robin Wishbone classic master serving NUM_CH requesters.
// Optional ack watchdog: define T08_WB_TIMEOUT_EN.
module t08_wb_multi_master #(
  parameter int NUM_CH         = 3,
  parameter int AW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NUM_CH-1:0]    req_read_i,
  input  logic [NUM_CH-1:0]    req_write_i,
  input  logic [NUM_CH*AW-1:0] req_adr_i,
  input  logic [NUM_CH*32-1:0] req_dat_i,
  input  logic [NUM_CH*4-1:0]  req_sel_i,
  output logic [31:0]          req_dat_o,
  output logic [NUM_CH-1:0]    req_done_o,
  output logic [NUM_CH-1:0]    req_busy_o,
  output logic [NUM_CH-1:0]    req_err_o,
  output logic [31:0]          wb_adr_o,
  output logic [31:0]          wb_dat_o,
  output logic [3:0]           wb_sel_o,
  output logic                 wb_we_o,
  output logic                 wb_stb_o,
  output logic                 wb_cyc_o,
  input  logic [31:0]          wb_dat_i,
  input  logic                 wb_ack_i
);

  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [NUM_CH-1:0] ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     last_q, last_d;
  logic [PW-1:0]     gnt_q, gnt_d;
  logic [31:0]       adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic [3:0]        sel_q, sel_d;
  logic              we_q, we_d;
  logic              stb_q, stb_d;
  logic [31:0]       rdat_q, rdat_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [NUM_CH-1:0] busy_q, busy_d;
  logic [NUM_CH-1:0] err_q, err_d;

`ifdef T08_WB_TIMEOUT_EN
  logic [15:0]       cnt_q, cnt_d;
`endif

  logic [NUM_CH-1:0] reqv;
  logic              hit;
  logic [PW-1:0]     pick;
  logic [31:0]       pick_adr;
  int                idx;

  assign reqv = req_read_i | req_write_i;

  // First requester after the last grant, wrapping modulo NUM_CH.
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    idx  = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(last_q) + k) % NUM_CH;
      if (!hit && reqv[idx]) begin
        hit  = 1'b1;
        pick = PW'(idx);
      end
    end
  end

  always_comb begin
    pick_adr = '0;
    pick_adr[AW-1:0] = req_adr_i[int'(pick)*AW +: AW];
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    stb_d   = stb_q;
    rdat_d  = rdat_q;
    busy_d  = busy_q;
    done_d  = '0;
    err_d   = '0;
`ifdef T08_WB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (en && hit) begin
          adr_d   = pick_adr;
          dat_d   = req_dat_i[int'(pick)*32 +: 32];
          sel_d   = req_sel_i[int'(pick)*4 +: 4];
          we_d    = req_write_i[pick];
          stb_d   = 1'b1;
          busy_d  = ONE << pick;
          last_d  = pick;
          gnt_d   = pick;
          state_d = S_BUS;
`ifdef T08_WB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_BUS: begin
        if (wb_ack_i) begin
          stb_d   = 1'b0;
          we_d    = 1'b0;
          busy_d  = '0;
          done_d  = ONE << gnt_q;
          if (!we_q) rdat_d = wb_dat_i;
          state_d = S_DONE;
        end
`ifdef T08_WB_TIMEOUT_EN
        else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          stb_d   = 1'b0;
          we_d    = 1'b0;
          busy_d  = '0;
          done_d  = ONE << gnt_q;
          err_d   = ONE << gnt_q;
          rdat_d  = 32'hDEAD_BEEF;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= PW'(NUM_CH - 1);
      gnt_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      stb_q   <= 1'b0;
      rdat_q  <= '0;
      done_q  <= '0;
      busy_q  <= '0;
      err_q   <= '0;
`ifdef T08_WB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      stb_q   <= stb_d;
      rdat_q  <= rdat_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
`ifdef T08_WB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_sel_o   = sel_q;
  assign wb_we_o    = we_q;
  assign wb_stb_o   = stb_q;
  assign wb_cyc_o   = stb_q;
  assign req_dat_o  = rdat_q;
  assign req_done_o = done_q;
  assign req_busy_o = busy_q;
  assign req_err_o  = err_q;

endmodule

// File: tb/tb_t08_wb_multi_master.sv
// Randomised + directed bench for t08_wb_multi_master with a
// transaction-level reference model.
module tb_t08_wb_multi_master;
  localparam int N  = 3;
  localparam int AW = 32;
`ifdef T08_WB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic           clk = 1'b0;
  logic           rst, en;
  logic [N-1:0]   rd, wr;
  logic [N*AW-1:0] adr;
  logic [N*32-1:0] wdat;
  logic [N*4-1:0] sel;
  logic [31:0]    req_dat_o;
  logic [N-1:0]   req_done_o, req_busy_o, req_err_o;
  logic [31:0]    wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]     wb_sel_o;
  logic           wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i;

  t08_wb_multi_master #(.NUM_CH(N), .AW(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_read_i(rd), .req_write_i(wr),
    .req_adr_i(adr), .req_dat_i(wdat), .req_sel_i(sel),
    .req_dat_o(req_dat_o), .req_done_o(req_done_o),
    .req_busy_o(req_busy_o), .req_err_o(req_err_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction, a one-cycle gap
  // after each completion, round-robin choice after the last grant.
  bit          m_act, m_gap, m_we, gfound;
  int          m_ch, m_last, m_n;
  logic [31:0] m_adr, m_dat, m_rdat;
  logic [3:0]  m_sel;
  logic [N-1:0] m_done, m_err;

  always @(posedge clk) begin
    m_done = '0;
    m_err  = '0;
    if (rst) begin
      m_act = 0; m_gap = 0; m_we = 0; m_ch = 0; m_n = 0;
      m_last = N - 1; m_rdat = 0; m_adr = 0; m_dat = 0; m_sel = 0;
    end else if (m_act) begin
      m_n++;
      if (wb_ack_i) begin
        m_act = 0; m_gap = 1; m_done[m_ch] = 1'b1;
        if (!m_we) m_rdat = wb_dat_i;
      end
`ifdef T08_WB_TIMEOUT_EN
      else if (m_n >= TO) begin
        m_act = 0; m_gap = 1; m_done[m_ch] = 1'b1; m_err[m_ch] = 1'b1;
        m_rdat = 32'hDEAD_BEEF;
      end
`endif
    end else if (m_gap) begin
      m_gap = 0;
    end else if (en) begin
      gfound = 0;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (!gfound && (rd[c] || wr[c])) begin
          gfound = 1;
          m_ch = c; m_last = c; m_we = wr[c]; m_act = 1; m_n = 0;
          m_adr = adr[c*AW +: AW];
          m_dat = wdat[c*32 +: 32];
          m_sel = sel[c*4 +: 4];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("stb", wb_stb_o, m_act);
      chk("cyc", wb_cyc_o, m_act);
      chk("we", wb_we_o, m_act & m_we);
      chk("busy", req_busy_o, m_act ? (32'd1 << m_ch) : 32'd0);
      chk("done", req_done_o, m_done);
      chk("err", req_err_o, m_err);
      chk("rdat", req_dat_o, m_rdat);
      if (m_act) begin
        chk("adr", wb_adr_o, m_adr);
        chk("wdat", wb_dat_o, m_dat);
        chk("sel", wb_sel_o, m_sel);
      end
    end
  end

  task automatic setch(input int c, input bit r, input bit w,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    rd[c] = r;
    wr[c] = w;
    adr[c*AW +: AW] = a;
    wdat[c*32 +: 32] = d;
    sel[c*4 +: 4] = s;
  endtask

  int          gch[6];
  int          gcyc[6];
  int          ng;
  logic [N-1:0] prev_busy, dropped;
  logic [31:0] r;

  initial begin
    rst = 1; en = 0; rd = '0; wr = '0; adr = '0; wdat = '0; sel = '0;
    wb_ack_i = 0; wb_dat_i = '0;
    repeat (2) @(negedge clk);
    cmp_on = 1;
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_rdat", req_dat_o, 0);
    chk("rst_busy", req_busy_o, 0);
    rst = 0; en = 1;

    // single read on ch1
    setch(1, 1, 0, 32'h3000_0010, 32'h0, 4'hF);
    @(negedge clk);
    chk("rd_stb", wb_stb_o, 1);
    chk("rd_we", wb_we_o, 0);
    chk("rd_adr", wb_adr_o, 32'h3000_0010);
    chk("rd_sel", wb_sel_o, 4'hF);
    @(negedge clk);
    wb_ack_i = 1; wb_dat_i = 32'hCAFE_0001;
    @(negedge clk);
    chk("rd_done", req_done_o, 3'b010);
    chk("rd_data", req_dat_o, 32'hCAFE_0001);
    wb_ack_i = 0; rd[1] = 0;
    @(negedge clk);
    chk("rd_done_pulse", req_done_o, 3'b000);

    // single write on ch0
    setch(0, 0, 1, 32'h3000_0004, 32'h1234_5678, 4'b0011);
    @(negedge clk);
    chk("wr_we", wb_we_o, 1);
    chk("wr_adr", wb_adr_o, 32'h3000_0004);
    chk("wr_dat", wb_dat_o, 32'h1234_5678);
    chk("wr_sel", wb_sel_o, 4'b0011);
    wb_ack_i = 1;
    @(negedge clk);
    chk("wr_done", req_done_o, 3'b001);
    chk("wr_rdat_kept", req_dat_o, 32'hCAFE_0001);
    wb_ack_i = 0; wr[0] = 0;
    @(negedge clk);

    // read+write together on ch2
    setch(2, 1, 1, 32'h3000_0020, 32'hA5A5_A5A5, 4'hF);
    @(negedge clk);
    chk("rw_we", wb_we_o, 1);
    chk("rw_busy", req_busy_o, 3'b100);
    wb_ack_i = 1;
    @(negedge clk);
    chk("rw_done", req_done_o, 3'b100);
    rd[2] = 0; wr[2] = 0; wb_ack_i = 0;
    repeat (4) @(negedge clk);
    chk("rw_single", wb_stb_o, 0);

    // round robin after reset
    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < N; i++)
      setch(i, 1, 0, 32'h3000_0100 + 32'(i * 4), 32'h0, 4'hF);
    ng = 0; prev_busy = '0; dropped = '0;
    for (int t = 0; t < 60 && ng < 6; t++) begin
      @(negedge clk);
      if (req_busy_o != 0 && prev_busy == 0) begin
        for (int i = 0; i < N; i++)
          if (req_busy_o[i]) gch[ng] = i;
        gcyc[ng] = t;
        ng++;
      end
      prev_busy = req_busy_o;
      for (int i = 0; i < N; i++) begin
        if (req_done_o[i]) begin
          rd[i] = 0; dropped[i] = 1;
        end else if (dropped[i]) begin
          rd[i] = 1; dropped[i] = 0;
        end
      end
      wb_ack_i = wb_stb_o;
    end
    chk("rr_count", ng, 6);
    for (int k = 0; k < 6; k++) begin
      chk("rr_order", gch[k], k % 3);
      if (k > 0) chk("rr_gap", gcyc[k] - gcyc[k-1], 3);
    end
    rd = '0;
    repeat (4) begin
      @(negedge clk);
      wb_ack_i = wb_stb_o;
    end
    wb_ack_i = 0;

    // en low ignores requests
    en = 0;
    for (int i = 0; i < N; i++) setch(i, 1, 0, 32'h3000_0200, 0, 4'hF);
    repeat (10) begin
      @(negedge clk);
      chk("en_off_stb", wb_stb_o, 0);
    end
    rd = '0; en = 1;
    @(negedge clk);

    // reset one cycle into BUS
    setch(1, 1, 0, 32'h3000_0300, 0, 4'h1);
    @(negedge clk);
    chk("rb_stb", wb_stb_o, 1);
    rst = 1; rd = '0;
    @(negedge clk);
    chk("rb_stb0", wb_stb_o, 0);
    chk("rb_cyc0", wb_cyc_o, 0);
    chk("rb_adr0", wb_adr_o, 0);
    chk("rb_sel0", wb_sel_o, 0);
    chk("rb_done0", req_done_o, 0);
    chk("rb_busy0", req_busy_o, 0);
    chk("rb_rdat0", req_dat_o, 0);
    rst = 0;
    setch(0, 1, 0, 32'h3000_0400, 0, 4'hF);
    setch(2, 1, 0, 32'h3000_0408, 0, 4'hF);
    @(negedge clk);
    chk("rb_first_ch0", req_busy_o, 3'b001);
    wb_ack_i = 1;
    @(negedge clk);
    rd = '0; wb_ack_i = 0;
    @(negedge clk);
    @(negedge clk);

    // no ack
    setch(0, 1, 0, 32'h3000_0500, 0, 4'hF);
    @(negedge clk);
    rd = '0;
`ifdef T08_WB_TIMEOUT_EN
    repeat (7) @(negedge clk);
    chk("to_stb_held", wb_stb_o, 1);
    @(negedge clk);
    chk("to_stb_drop", wb_stb_o, 0);
    chk("to_err", req_err_o, 3'b001);
    chk("to_done", req_done_o, 3'b001);
    chk("to_dat", req_dat_o, 32'hDEAD_BEEF);
    @(negedge clk);
`else
    repeat (100) begin
      @(negedge clk);
      chk("noto_stb", wb_stb_o, 1);
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
`endif

    // randomized traffic
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      en = ($urandom_range(0, 9) != 0);
      wb_ack_i = wb_stb_o && ($urandom_range(0, 2) == 0);
      wb_dat_i = $urandom;
      for (int i = 0; i < N; i++) begin
        if (req_done_o[i]) begin
          rd[i] = 0; wr[i] = 0;
        end else if (!(rd[i] | wr[i]) && $urandom_range(0, 3) == 0) begin
          r = $urandom;
          case (r[1:0])
            2'd0: setch(i, 1, 0, $urandom, $urandom, 4'($urandom));
            2'd1: setch(i, 0, 1, $urandom, $urandom, 4'($urandom));
            default: setch(i, 1, 1, $urandom, $urandom, 4'($urandom));
          endcase
        end
      end
    end
    rst = 0; rd = '0; wr = '0; wb_ack_i = 0;
    repeat (2) @(negedge clk);
    cmp_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
